// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-set digit editor: key indices, FSM states
// and the wrapped BCD digit step.
package time_set_pkg;

    localparam int unsigned KEY_LEFT  = 0;
    localparam int unsigned KEY_RIGHT = 1;
    localparam int unsigned KEY_INC   = 2;
    localparam int unsigned KEY_DEC   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNAP,
        ST_EDIT,
        ST_COMMIT
    } state_e;

    function automatic logic [3:0] digit_step(input logic [3:0] value,
                                              input logic [3:0] dmax,
                                              input logic       up);
        if (up) begin
            return (value >= dmax) ? 4'd0 : value + 4'd1;
        end
        return (value == 4'd0) ? dmax : value - 4'd1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Editor-side bundle: live time and keys in, edited/displayed time and status out.
interface time_set_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 6
);
    localparam int unsigned CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    edit_en;
    logic [3:0]              key;
    logic [NUM_DIGITS*4-1:0] time_in;
    logic [NUM_DIGITS*4-1:0] time_out;
    logic [CW-1:0]           cursor;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    editing;
    logic                    apply;

    modport master (
        output edit_en, key, time_in,
        input  time_out, cursor, blink_mask, editing, apply
    );

    modport slave (
        input  edit_en, key, time_in,
        output time_out, cursor, blink_mask, editing, apply
    );

endinterface

// File: rtl/time_set_ctrl_key_repeat.sv
// Key front end: one-hot validation, press detection and inc/dec auto-repeat.
// Fire outputs are single-cycle and combinational from the current key.
module key_repeat
    import time_set_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input  logic       clk,
    input  logic       resett,
    input  logic [3:0] key_i,
    output logic       left_o,
    output logic       right_o,
    output logic       inc_o,
    output logic       dec_o
);

    logic [3:0]  prev_key_q;
    logic [31:0] cnt_q;
    logic        first_done_q;

    logic        valid;
    logic        changed;
    logic        held;
    logic        rep_fire;
    logic        fire;
    logic [31:0] cnt_inc;

    always_comb begin
        valid    = $onehot(key_i);
        changed  = (key_i != prev_key_q);
        held     = valid && !changed && (key_i[KEY_INC] || key_i[KEY_DEC]);
        cnt_inc  = cnt_q + 32'd1;
        rep_fire = held && (cnt_inc == (first_done_q ? REPEAT_RATE : REPEAT_DELAY));
        fire     = (valid && changed) || rep_fire;
        left_o   = fire && key_i[KEY_LEFT];
        right_o  = fire && key_i[KEY_RIGHT];
        inc_o    = fire && key_i[KEY_INC];
        dec_o    = fire && key_i[KEY_DEC];
    end

    always_ff @(posedge clk) begin
        if (resett) begin
            prev_key_q   <= '0;
            cnt_q        <= '0;
            first_done_q <= 1'b0;
        end else begin
            prev_key_q <= key_i;
            if (!held) begin
                cnt_q        <= '0;
                first_done_q <= 1'b0;
            end else if (rep_fire) begin
                cnt_q        <= '0;
                first_done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Digit editor between the BCD time counter and the display path: pass-through
// when idle, shadow-register editing with cursor/blink while edit_en is high.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned            NUM_DIGITS   = 6,
    parameter logic [NUM_DIGITS*4-1:0] DIGIT_MAX   = {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9},
    parameter int unsigned            REPEAT_DELAY = 50_000_000,
    parameter int unsigned            REPEAT_RATE  = 10_000_000,
    parameter int unsigned            BLINK_DIV    = 25_000_000
) (
    input logic            clk,
    input logic            resett,
    time_set_ctrl_if.slave bus
);

    localparam int unsigned CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned W  = NUM_DIGITS * 4;

    state_e                state_q, state_d;
    logic [W-1:0]          shadow_q, shadow_d;
    logic [W-1:0]          time_out_q, time_out_d;
    logic [CW-1:0]         cursor_q, cursor_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic                  phase_q, phase_d;
    logic [31:0]           bcnt_q, bcnt_d;
    logic                  pend_q, pend_d;
    logic                  prev_edit_q;
    logic                  editing_q;
    logic                  apply_q;

    logic                  fire_left, fire_right, fire_inc, fire_dec;
    logic                  rise;
    logic [3:0]            cur_digit, cur_max;

    key_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_key_repeat (
        .clk    (clk),
        .resett (resett),
        .key_i  (bus.key),
        .left_o (fire_left),
        .right_o(fire_right),
        .inc_o  (fire_inc),
        .dec_o  (fire_dec)
    );

    function automatic logic [W-1:0] sanitize(input logic [W-1:0] t);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            r[i*4 +: 4] = (t[i*4 +: 4] > DIGIT_MAX[i*4 +: 4]) ? 4'd0 : t[i*4 +: 4];
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        time_out_d = time_out_q;
        cursor_d   = cursor_q;
        phase_d    = phase_q;
        bcnt_d     = bcnt_q;
        pend_d     = pend_q;
        rise       = bus.edit_en && !prev_edit_q;
        cur_digit  = shadow_q[{cursor_q, 2'b00} +: 4];
        cur_max    = DIGIT_MAX[{cursor_q, 2'b00} +: 4];

        case (state_q)
            ST_IDLE: begin
                time_out_d = bus.time_in;
                pend_d     = 1'b0;
                if (rise || pend_q) state_d = ST_SNAP;
            end
            ST_SNAP: begin
                shadow_d   = sanitize(bus.time_in);
                time_out_d = shadow_d;
                cursor_d   = '0;
                bcnt_d     = '0;
                phase_d    = 1'b0;
                state_d    = ST_EDIT;
            end
            ST_EDIT: begin
                time_out_d = shadow_q;
                // Level test also covers edit_en dropping during SNAP.
                if (!bus.edit_en) begin
                    state_d = ST_COMMIT;
                end else begin
                    if (bcnt_q == BLINK_DIV - 1) begin
                        bcnt_d  = '0;
                        phase_d = !phase_q;
                    end else begin
                        bcnt_d = bcnt_q + 32'd1;
                    end
                    if (fire_left || fire_right || fire_inc || fire_dec) begin
                        phase_d = 1'b1;
                        bcnt_d  = '0;
                    end
                    if (fire_left)
                        cursor_d = (cursor_q == CW'(NUM_DIGITS - 1)) ? '0 : cursor_q + CW'(1);
                    if (fire_right)
                        cursor_d = (cursor_q == '0) ? CW'(NUM_DIGITS - 1) : cursor_q - CW'(1);
                    if (fire_inc)
                        shadow_d[{cursor_q, 2'b00} +: 4] = digit_step(cur_digit, cur_max, 1'b1);
                    if (fire_dec)
                        shadow_d[{cursor_q, 2'b00} +: 4] = digit_step(cur_digit, cur_max, 1'b0);
                end
            end
            ST_COMMIT: begin
                time_out_d = shadow_q;
                state_d    = ST_IDLE;
                pend_d     = rise;
            end
            default: state_d = ST_IDLE;
        endcase

        mask_d = '0;
        if (state_d == ST_EDIT && phase_d) mask_d = NUM_DIGITS'(1) << cursor_d;
    end

    always_ff @(posedge clk) begin
        if (resett) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            time_out_q  <= '0;
            cursor_q    <= '0;
            mask_q      <= '0;
            phase_q     <= 1'b0;
            bcnt_q      <= '0;
            pend_q      <= 1'b0;
            prev_edit_q <= 1'b0;
            editing_q   <= 1'b0;
            apply_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            time_out_q  <= time_out_d;
            cursor_q    <= cursor_d;
            mask_q      <= mask_d;
            phase_q     <= phase_d;
            bcnt_q      <= bcnt_d;
            pend_q      <= pend_d;
            prev_edit_q <= bus.edit_en;
            editing_q   <= (state_d != ST_IDLE);
            apply_q     <= (state_d == ST_COMMIT);
        end
    end

    assign bus.time_out   = time_out_q;
    assign bus.cursor     = cursor_q;
    assign bus.blink_mask = mask_q;
    assign bus.editing    = editing_q;
    assign bus.apply      = apply_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scenario bench for time_set_ctrl with a digit-array reference model of the editor.
module tb_time_set_ctrl;

    logic clk = 1'b0;
    logic resett = 1'b1;
    always #5 clk = ~clk;

    time_set_ctrl_if #(.NUM_DIGITS(6)) bus ();

    time_set_ctrl #(
        .NUM_DIGITS  (6),
        .DIGIT_MAX   (24'h295959),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5),
        .BLINK_DIV   (8)
    ) dut (
        .clk   (clk),
        .resett(resett),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int dmax[6] = '{9, 5, 9, 5, 9, 2};
    int m_dig[6];
    int m_cur;

    function automatic logic [23:0] m_pack();
        logic [23:0] r;
        for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'(m_dig[i]);
        return r;
    endfunction

    function automatic void m_load(input logic [23:0] t);
        for (int i = 0; i < 6; i++) begin
            int d;
            d = int'(t[i*4 +: 4]);
            m_dig[i] = (d > dmax[i]) ? 0 : d;
        end
        m_cur = 0;
    endfunction

    function automatic void m_key(input int k);
        case (k)
            0: m_cur = (m_cur + 1) % 6;
            1: m_cur = (m_cur + 5) % 6;
            2: m_dig[m_cur] = (m_dig[m_cur] + 1) % (dmax[m_cur] + 1);
            default: m_dig[m_cur] = (m_dig[m_cur] + dmax[m_cur]) % (dmax[m_cur] + 1);
        endcase
    endfunction

    // Number of actions when an inc/dec key is held for n consecutive cycles.
    function automatic int exp_fires(input int n);
        if (n - 1 < 20) return 1;
        return 2 + (n - 1 - 20) / 5;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        bus.key = 4'(1 << k);
        step(1);
        bus.key = '0;
        step(1);
        m_key(k);
    endtask

    task automatic enter_edit(input logic [23:0] t);
        bus.time_in = t;
        bus.edit_en = 1'b1;
        step(2);
        m_load(t);
    endtask

    task automatic test_reset();
        resett = 1'b1;
        step(2);
        checks++;
        if (bus.time_out !== 24'h0 || bus.cursor !== 3'd0 || bus.blink_mask !== 6'd0) begin
            errors++;
            $display("FAIL reset_data time_out=%h cursor=%0d mask=%b required 0/0/0",
                     bus.time_out, bus.cursor, bus.blink_mask);
        end
        checks++;
        if (bus.editing !== 1'b0 || bus.apply !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags editing=%b apply=%b required 0/0", bus.editing, bus.apply);
        end
    endtask

    task automatic test_passthrough();
        logic [23:0] t;
        bus.time_in = 24'h123456;
        resett = 1'b0;
        step(1);
        checks++;
        if (bus.time_out !== 24'h123456 || bus.editing !== 1'b0 || bus.apply !== 1'b0) begin
            errors++;
            $display("FAIL passthrough time_out=%h editing=%b apply=%b required 123456/0/0",
                     bus.time_out, bus.editing, bus.apply);
        end
        for (int i = 0; i < 4; i++) begin
            t = 24'($urandom);
            bus.time_in = t;
            step(1);
            checks++;
            if (bus.time_out !== t) begin
                errors++;
                $display("FAIL passthrough_rand time_out=%h required %h", bus.time_out, t);
            end
        end
    endtask

    task automatic test_snapshot();
        enter_edit(24'h235959);
        checks++;
        if (bus.time_out !== 24'h235959 || bus.editing !== 1'b1 || bus.cursor !== 3'd0) begin
            errors++;
            $display("FAIL snapshot time_out=%h editing=%b cursor=%0d required 235959/1/0",
                     bus.time_out, bus.editing, bus.cursor);
        end
        bus.time_in = 24'($urandom);
        press(2);
        checks++;
        if (bus.time_out !== 24'h235950 || bus.time_out !== m_pack()) begin
            errors++;
            $display("FAIL inc_wrap time_out=%h required 235950", bus.time_out);
        end
        bus.time_in = 24'($urandom);
        step(3);
        checks++;
        if (bus.time_out !== m_pack()) begin
            errors++;
            $display("FAIL edit_hold time_out=%h required %h", bus.time_out, m_pack());
        end
    endtask

    task automatic test_cursor_wrap();
        press(1);
        checks++;
        if (bus.cursor !== 3'd5) begin
            errors++;
            $display("FAIL right_wrap cursor=%0d required 5", bus.cursor);
        end
        press(2);
        checks++;
        if (bus.time_out !== 24'h035950) begin
            errors++;
            $display("FAIL digit5_wrap time_out=%h required 035950", bus.time_out);
        end
        press(0);
        checks++;
        if (bus.cursor !== 3'd0) begin
            errors++;
            $display("FAIL left_wrap cursor=%0d required 0", bus.cursor);
        end
    endtask

    task automatic test_illegal();
        bus.key = 4'b0110;
        step(3);
        bus.key = 4'b1100;
        step(3);
        bus.key = 4'b0000;
        step(2);
        checks++;
        if (bus.time_out !== m_pack() || bus.cursor !== 3'(m_cur)) begin
            errors++;
            $display("FAIL illegal_keys time_out=%h cursor=%0d required %h/%0d",
                     bus.time_out, bus.cursor, m_pack(), m_cur);
        end
    endtask

    task automatic test_repeat();
        int k, n;
        press(0);
        press(3);
        press(3);
        checks++;
        if (bus.time_out !== 24'h035930) begin
            errors++;
            $display("FAIL pre_repeat time_out=%h required 035930", bus.time_out);
        end
        bus.key = 4'b1000;
        step(31);
        bus.key = '0;
        step(2);
        checks++;
        if (bus.time_out !== 24'h035950) begin
            errors++;
            $display("FAIL repeat_dec time_out=%h required 035950", bus.time_out);
        end
        repeat (exp_fires(31)) m_key(3);
        for (int i = 0; i < 4; i++) begin
            k = int'($urandom_range(2, 3));
            n = int'($urandom_range(1, 45));
            bus.key = 4'(1 << k);
            step(n);
            bus.key = '0;
            step(2);
            repeat (exp_fires(n)) m_key(k);
            checks++;
            if (bus.time_out !== m_pack()) begin
                errors++;
                $display("FAIL repeat_rand key=%0d hold=%0d time_out=%h required %h",
                         k, n, bus.time_out, m_pack());
            end
        end
    endtask

    task automatic test_blink();
        logic [5:0] on;
        press(2);
        on = 6'(1 << m_cur);
        checks++;
        if (bus.blink_mask !== on) begin
            errors++;
            $display("FAIL blink_after_key mask=%b required %b", bus.blink_mask, on);
        end
        step(6);
        checks++;
        if (bus.blink_mask !== on) begin
            errors++;
            $display("FAIL blink_still_on mask=%b required %b", bus.blink_mask, on);
        end
        step(1);
        checks++;
        if (bus.blink_mask !== 6'd0) begin
            errors++;
            $display("FAIL blink_off mask=%b required 000000", bus.blink_mask);
        end
        step(8);
        checks++;
        if (bus.blink_mask !== on) begin
            errors++;
            $display("FAIL blink_back_on mask=%b required %b", bus.blink_mask, on);
        end
    endtask

    task automatic test_commit();
        int pulses;
        logic [23:0] t;
        t = 24'($urandom);
        bus.edit_en = 1'b0;
        bus.time_in = t;
        step(1);
        pulses = int'(bus.apply);
        checks++;
        if (bus.apply !== 1'b1 || bus.time_out !== m_pack() || bus.blink_mask !== 6'd0) begin
            errors++;
            $display("FAIL commit apply=%b time_out=%h mask=%b required 1/%h/000000",
                     bus.apply, bus.time_out, bus.blink_mask, m_pack());
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            pulses += int'(bus.apply);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL apply_pulses count=%0d required 1", pulses);
        end
        checks++;
        if (bus.time_out !== t || bus.editing !== 1'b0) begin
            errors++;
            $display("FAIL post_commit time_out=%h editing=%b required %h/0",
                     bus.time_out, bus.editing, t);
        end
    endtask

    task automatic test_out_of_range();
        enter_edit(24'h7F5959);
        checks++;
        if (bus.time_out !== 24'h005959 || bus.time_out !== m_pack()) begin
            errors++;
            $display("FAIL snap_sanitize time_out=%h required 005959", bus.time_out);
        end
        bus.edit_en = 1'b0;
        step(2);
    endtask

    task automatic test_random();
        int k;
        logic [23:0] t;
        for (int s = 0; s < 3; s++) begin
            t = 24'($urandom);
            enter_edit(t);
            checks++;
            if (bus.time_out !== m_pack()) begin
                errors++;
                $display("FAIL rand_snap in=%h time_out=%h required %h", t, bus.time_out, m_pack());
            end
            for (int j = 0; j < 12; j++) begin
                k = int'($urandom_range(0, 3));
                press(k);
                checks++;
                if (bus.time_out !== m_pack() || bus.cursor !== 3'(m_cur)) begin
                    errors++;
                    $display("FAIL rand_key key=%0d time_out=%h cursor=%0d required %h/%0d",
                             k, bus.time_out, bus.cursor, m_pack(), m_cur);
                end
            end
            bus.edit_en = 1'b0;
            step(1);
            checks++;
            if (bus.apply !== 1'b1 || bus.time_out !== m_pack()) begin
                errors++;
                $display("FAIL rand_commit apply=%b time_out=%h required 1/%h",
                         bus.apply, bus.time_out, m_pack());
            end
            step(1);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        enter_edit(24'($urandom));
        press(2);
        resett = 1'b1;
        bus.edit_en = 1'b0;
        step(1);
        checks++;
        if (bus.time_out !== 24'h0 || bus.apply !== 1'b0 || bus.editing !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort time_out=%h apply=%b editing=%b required 0/0/0",
                     bus.time_out, bus.apply, bus.editing);
        end
        resett = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            pulses += int'(bus.apply);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_abort_apply count=%0d required 0", pulses);
        end
    endtask

    initial begin
        bus.edit_en = 1'b0;
        bus.key     = '0;
        bus.time_in = '0;
        m_load('0);
        test_reset();
        test_passthrough();
        test_snapshot();
        test_cursor_wrap();
        test_illegal();
        test_repeat();
        test_blink();
        test_commit();
        test_out_of_range();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Parametrised digit-editor for the clock display path. It sits between the free-running BCD time counter and the display/UART formatter. With edit_en low it passes the live time through. With edit_en high it snapshots the time into a shadow register, then lets four keys move a cursor and increment/decrement individual digits, with per-digit modulus and auto-repeat. It pulses apply when editing ends so the counter can load the edited value.

Parameters:
NUM_DIGITS, 6, number of BCD digits; digit 0 is least significant (sec_l).
DIGIT_MAX, {4'd2,4'd9,4'd5,4'd9,4'd5,4'd9}, packed NUM_DIGITS*4 per-digit maximum; the MSB nibble belongs to the highest digit.
REPEAT_DELAY, 50_000_000, cycles an inc/dec key is held before the first auto-repeat.
REPEAT_RATE, 10_000_000, cycles between auto-repeats after the first one.
BLINK_DIV, 25_000_000, cycles per blink half-period.

Ports:
clk  in  1  system clock
resett  in  1  synchronous, active-high reset
edit_en  in  1  level; high = edit mode
key  in  4  [0]=left, [1]=right, [2]=inc, [3]=dec; debounced, active-high
time_in  in  NUM_DIGITS*4  live BCD time from counter
time_out  out  NUM_DIGITS*4  displayed/committed time
cursor  out  clog2(NUM_DIGITS)  selected digit index
blink_mask  out  NUM_DIGITS  one-hot cursor gated by blink phase
editing  out  1  high in SNAP/EDIT/COMMIT
apply  out  1  one-cycle pulse; the counter loads time_out when it sees this pulse

Behaviour:
- Clock is clk. Reset is synchronous and active-high on resett; polarity and synchronicity are fixed.
- Reset state: time_out=0, cursor=0, blink_mask=0, editing=0, apply=0, shadow=0, FSM=IDLE, repeat/blink counters=0, prev_key=0, prev_edit_en=0. Reset asserted mid-edit aborts the edit with no apply.
- FSM states: IDLE, SNAP, EDIT, COMMIT.
- IDLE: time_out<=time_in each cycle (1-cycle latency). Move to SNAP on an edit_en rising edge (edit_en=1, prev_edit_en=0).
- SNAP (1 cycle): shadow<=time_in. Any digit greater than its DIGIT_MAX loads as 0. cursor<=0. Blink counter and phase clear. Go to EDIT.
- EDIT: time_out<=shadow every cycle. On an edit_en falling edge go to COMMIT; the key action in that same cycle is ignored.
- COMMIT (1 cycle): apply=1 and time_out=shadow. Go to IDLE. If edit_en is high again during COMMIT, go to SNAP on the next cycle after IDLE (rising edge detection still applies).
- Key acceptance: an action fires only when key is exactly one-hot. 0 or multi-bit values do nothing and reset the repeat counter.
- A press event is a key value change from the previous cycle to a valid one-hot value.
- Left: cursor+1, wrapping NUM_DIGITS-1 to 0. Right: cursor-1, wrapping 0 to NUM_DIGITS-1. No auto-repeat for left/right.
- Inc on shadow[cursor]: +1, wrapping DIGIT_MAX to 0. Dec: -1, wrapping 0 to DIGIT_MAX.
- The result is visible on time_out 2 cycles after the press (1 cycle to update shadow, 1 cycle to register time_out).
- Auto-repeat: inc/dec held unchanged increments the repeat counter.
  - First repeat fires at count REPEAT_DELAY.
  - Later repeats fire every REPEAT_RATE cycles.
  - Any key change restarts the counter at 0.
- Blink: a counter toggles the blink phase every BLINK_DIV cycles while in EDIT. blink_mask = (1<<cursor) when phase=1, else 0. The phase clears to 1 on every accepted key event so the cursor stays visible while keys are used. blink_mask=0 outside EDIT.
- No composite-field validation: hours 24–29 are reachable. The counter owns range checks on load.

Decomposition:
- Package time_set_pkg holds:
  - key bit index constants KEY_LEFT=0, KEY_RIGHT=1, KEY_INC=2, KEY_DEC=3;
  - the FSM state enum;
  - the function digit_step(value, max, up) returning the wrapped BCD nibble.
- One sub-module, key_repeat: per-key edge detect, one-hot validation and the auto-repeat counter. It outputs single-cycle fire pulses for left/right/inc/dec. Blink and digit datapath stay in the top level.

Test Plan:
- Pass-through: edit_en=0, time_in=0x123456, reset released → time_out=0x123456 one cycle later, editing=0, apply=0.
- Snapshot/edit: time_in=0x235959, raise edit_en, press inc once → shadow digit0 wraps 9→0, time_out=0x235950 two cycles after the press; time_in changes are ignored while editing.
- Cursor wrap: press right at cursor=0 → cursor=5; press inc → digit5 wraps 2→0; press left → cursor=0.
- Auto-repeat with REPEAT_DELAY=20, REPEAT_RATE=5: hold dec at digit1=3 for 31 cycles → exactly 4 decrements (press, then at 20, 25, 30) → digit1 goes 3→2→1→0→5.
- Commit: drop edit_en → apply high for exactly 1 cycle with time_out=shadow, then IDLE pass-through. Asserting resett mid-EDIT instead → no apply pulse, time_out=0.
- Illegal keys: key=4'b0110, then key=4'b0000 → no shadow or cursor change. Snapshot of out-of-range time_in=0x7F5959 → shadow=0x005959.
